// File: rtl/power_effect_timer.sv
// power_effect_timer: Pac-Man power-bean effect timer with ghost fright and eat-combo tracking (optional pause via POWER_PAUSE_EN)
module power_effect_timer #(
  parameter int CNT_W      = 4,
  parameter int DURATION   = 8,
  parameter int WARN_MOVES = 3,
  parameter int NUM_GHOSTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            scene,
  input  logic                  move_tick,
  input  logic                  power,
  input  logic [NUM_GHOSTS-1:0] ghost_eaten,
  input  logic                  pause,
  output logic                  power_active,
  output logic                  power_warn,
  output logic [CNT_W-1:0]      power_cnt,
  output logic [NUM_GHOSTS-1:0] ghost_fright,
  output logic                  eat_valid,
  output logic [1:0]            eat_combo,
  output logic                  power_done
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WARN} state_t;
  state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt, w_dec;
  logic [NUM_GHOSTS-1:0] r_fright, w_fright, w_valid;
  logic [1:0] r_combo, w_combo, r_eat_combo, w_eat_combo;
  logic [7:0] w_sum;
  logic r_eat_valid, w_eat_valid, r_done, w_done, r_active, r_warn, w_tick;
`ifdef POWER_PAUSE_EN
  assign w_tick = move_tick & ~pause;
`else
  assign w_tick = move_tick & (pause | 1'b1);
`endif
  // State register
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_state;
  // Next state and next register values: scene reset beats power beats tick/eat
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_fright = r_fright;
    w_combo = r_combo;
    w_eat_valid = 1'b0;
    w_eat_combo = 2'd0;
    w_done = 1'b0;
    w_valid = ghost_eaten & r_fright & {NUM_GHOSTS{r_state != S_IDLE}};
    w_dec = r_cnt - CNT_W'(1);
    w_sum = {6'd0, r_combo};
    for (int i = 0; i < NUM_GHOSTS; i++) w_sum = w_sum + 8'(w_valid[i]);
    if (scene == 2'b00) begin
      w_state = S_IDLE;
      w_cnt = '0;
      w_fright = '0;
      w_combo = '0;
    end else if (power) begin
      w_state = S_ACTIVE;
      w_cnt = CNT_W'(DURATION);
      w_fright = '1;
      w_combo = '0;
    end else begin
      if (|w_valid) begin
        w_eat_valid = 1'b1;
        w_eat_combo = r_combo;
        w_combo = w_sum > 8'd3 ? 2'd3 : w_sum[1:0];
        w_fright = r_fright & ~w_valid;
      end
      if (w_tick && r_state != S_IDLE) begin
        w_cnt = w_dec;
        w_state = w_dec == '0 ? S_IDLE : w_dec > CNT_W'(WARN_MOVES) ? S_ACTIVE : S_WARN;
        if (w_dec == '0) begin
          w_done = 1'b1;
          w_fright = '0;
          w_combo = '0;
        end
      end
    end
  end
  // Datapath and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= '0;
      r_fright <= '0;
      r_combo <= '0;
      r_eat_valid <= 1'b0;
      r_eat_combo <= 2'd0;
      r_done <= 1'b0;
      r_active <= 1'b0;
      r_warn <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_fright <= w_fright;
      r_combo <= w_combo;
      r_eat_valid <= w_eat_valid;
      r_eat_combo <= w_eat_combo;
      r_done <= w_done;
      r_active <= w_state != S_IDLE;
      r_warn <= w_state == S_WARN;
    end
  assign power_active = r_active;
  assign power_warn = r_warn;
  assign power_cnt = r_cnt;
  assign ghost_fright = r_fright;
  assign eat_valid = r_eat_valid;
  assign eat_combo = r_eat_combo;
  assign power_done = r_done;
endmodule

// File: tb/tb_power_effect_timer.sv
// tb_power_effect_timer: vector table with expected-output scoreboard for power_effect_timer
module tb_power_effect_timer;
  logic clk = 1'b0, rst = 1'b1, move_tick = 1'b0, power = 1'b0, pause = 1'b0;
  logic [1:0] scene = 2'b01;
  logic [3:0] ghost_eaten = 4'd0;
  logic power_active, power_warn, eat_valid, power_done;
  logic [3:0] power_cnt, ghost_fright;
  logic [1:0] eat_combo;
  int tests = 0, fails = 0;
  typedef struct {
    logic r, tk, pw, pa;
    logic [1:0] sc;
    logic [3:0] g;
    logic a, w, ev, d;
    logic [3:0] c, f;
    logic [1:0] ec;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];
  power_effect_timer dut (
    .clk(clk), .rst(rst), .scene(scene), .move_tick(move_tick), .power(power),
    .ghost_eaten(ghost_eaten), .pause(pause), .power_active(power_active),
    .power_warn(power_warn), .power_cnt(power_cnt), .ghost_fright(ghost_fright),
    .eat_valid(eat_valid), .eat_combo(eat_combo), .power_done(power_done)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [1:0] sc, input logic tk, input logic pw,
                     input logic [3:0] g, input logic pa, input logic a, input logic w,
                     input int c, input logic [3:0] f, input logic ev, input int ec, input logic d);
    vec_t v;
    v.r = r; v.sc = sc; v.tk = tk; v.pw = pw; v.g = g; v.pa = pa;
    v.a = a; v.w = w; v.c = 4'(c); v.f = f; v.ev = ev; v.ec = 2'(ec); v.d = d;
    vecs.push_back(v);
  endtask
  task automatic chk(input string n, input int row, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0d expected %0d", n, row, act, exp);
    end
  endtask
  task automatic ticks(input int n, input int start);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = start - k;
      add(0, 1, 1, 0, 0, 0, c > 0, c >= 1 && c <= 3, c, c > 0 ? 4'hF : 4'h0, 0, 0, c == 0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    ticks(8, 8);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    ticks(5, 8);
    add(0, 1, 0, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    add(0, 1, 0, 0, 4'h1, 0, 1, 0, 8, 4'hE, 1, 0, 0);
    add(0, 1, 0, 0, 4'h2, 0, 1, 0, 8, 4'hC, 1, 1, 0);
    add(0, 1, 0, 0, 4'h4, 0, 1, 0, 8, 4'h8, 1, 2, 0);
    add(0, 1, 0, 0, 4'h8, 0, 1, 0, 8, 4'h0, 1, 3, 0);
    add(0, 1, 0, 0, 4'h1, 0, 1, 0, 8, 4'h0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    add(0, 1, 0, 0, 4'h3, 0, 1, 0, 8, 4'hC, 1, 0, 0);
    add(0, 1, 0, 0, 4'h4, 0, 1, 0, 8, 4'h8, 1, 2, 0);
    add(0, 1, 0, 0, 4'h8, 0, 1, 0, 8, 4'h0, 1, 3, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    ticks(7, 8);
    add(0, 1, 1, 0, 4'h1, 0, 0, 0, 0, 4'h0, 1, 0, 1);
    add(0, 1, 0, 0, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    add(0, 1, 0, 1, 4'h1, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    ticks(6, 8);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    ticks(6, 8);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 8, 4'hF, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
`ifdef POWER_PAUSE_EN
      add(0, 1, 1, 0, 0, 1, 1, 0, 8, 4'hF, 0, 0, 0);
`else
      int c;
      c = k <= 8 ? 8 - k : 0;
      add(0, 1, 1, 0, 0, 1, c > 0, c >= 1 && c <= 3, c, c > 0 ? 4'hF : 4'h0, 0, 0, k == 8);
`endif
    end
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      @(negedge clk);
      rst = vecs[i].r; scene = vecs[i].sc; move_tick = vecs[i].tk; power = vecs[i].pw;
      ghost_eaten = vecs[i].g; pause = vecs[i].pa;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("power_active", i, int'(power_active), int'(e.a));
      chk("power_warn", i, int'(power_warn), int'(e.w));
      chk("power_cnt", i, int'(power_cnt), int'(e.c));
      chk("ghost_fright", i, int'(ghost_fright), int'(e.f));
      chk("eat_valid", i, int'(eat_valid), int'(e.ev));
      if (e.ev || e.r) chk("eat_combo", i, int'(eat_combo), int'(e.ec));
      chk("power_done", i, int'(power_done), int'(e.d));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/power_effect_timer.md
POWER_EFFECT_TIMER -- requirements
Module: power_effect_timer

Interface
REQ-001 Parameter CNT_W, default 4, width of the remaining-moves counter.
REQ-002 Parameter DURATION, default 8, moves the power effect lasts; SHALL satisfy 1 <= DURATION <= 2^CNT_W-1.
REQ-003 Parameter WARN_MOVES, default 3, final moves flagged as warning (ghost blink); SHALL satisfy WARN_MOVES < DURATION.
REQ-004 Parameter NUM_GHOSTS, default 4, number of ghost channels.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 scene  input  2  game scene; 2'b00 = title/idle scene.
REQ-008 move_tick  input  1  single-cycle strobe, one per Pac-Man move.
REQ-009 power  input  1  single-cycle strobe, power bean eaten.
REQ-010 ghost_eaten  input  NUM_GHOSTS  per-ghost single-cycle strobe, Pac-Man collided with ghost i.
REQ-011 pause  input  1  freeze request (used only under POWER_PAUSE_EN).
REQ-012 power_active  output  1  effect running (state ACTIVE or WARN).
REQ-013 power_warn  output  1  state WARN.
REQ-014 power_cnt  output  CNT_W  remaining moves.
REQ-015 ghost_fright  output  NUM_GHOSTS  ghost i currently frightened.
REQ-016 eat_valid  output  1  one-cycle pulse: at least one frightened ghost eaten.
REQ-017 eat_combo  output  2  combo index for that eat (0..3 = 200/400/800/1600), valid with eat_valid.
REQ-018 power_done  output  1  one-cycle pulse when the effect expires.

Function
REQ-019 FSM states IDLE, ACTIVE, WARN; all outputs registered.
REQ-020 Priority per cycle: rst > scene==2'b00 > power > move_tick/ghost_eaten.
REQ-021 power in any state: next cycle power_cnt=DURATION, ghost_fright all ones, combo=0, state ACTIVE (WARN if DURATION<=WARN_MOVES is excluded by REQ-003); re-trigger reloads, no accumulation.
REQ-022 power and move_tick in the same cycle: the tick is ignored (cnt=DURATION).
REQ-023 move_tick in ACTIVE/WARN: power_cnt decrements by 1; in IDLE: no effect, power_cnt holds 0.
REQ-024 State after decrement: cnt>WARN_MOVES -> ACTIVE; 1..WARN_MOVES -> WARN; 0 -> IDLE.
REQ-025 On transition to IDLE via tick: power_done=1 for exactly one cycle, ghost_fright cleared, combo cleared.
REQ-026 ghost_eaten[i] with ghost_fright[i]=1 and power_active: ghost_fright[i] clears next cycle; ignored otherwise.
REQ-027 Valid eats in a cycle: eat_valid=1 next cycle, eat_combo=combo before the eat, combo += number of valid eats, saturating at 3.
REQ-028 ghost_eaten and move_tick in the same cycle: both processed; on expiring tick, eat is still reported, fright/combo then cleared.
REQ-029 power and ghost_eaten in the same cycle: power wins; eat ignored, no eat_valid.
REQ-030 scene==2'b00: same effect as reset (REQ-031), no power_done pulse.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, power_cnt=0, ghost_fright=0, combo=0, eat_valid=0, eat_combo=0, power_done=0, power_active=0, power_warn=0.
REQ-032 Reset mid-effect SHALL abort without power_done.

Configuration
REQ-033 Macro POWER_PAUSE_EN: when defined, pause=1 suppresses move_tick decrements and freezes state; power, ghost_eaten, rst, scene still act; when undefined, pause is ignored.

Verification
REQ-034 Defaults; rst, power, 8 ticks -> power_cnt 8..0, power_warn during cnt 3..1, power_done pulse after 8th tick, ghost_fright 4'b0000.
REQ-035 power, 5 ticks (cnt=3), power again -> cnt=8, ACTIVE, ghost_fright 4'b1111, no power_done.
REQ-036 power, then ghost_eaten 4'b0001, 4'b0010, 4'b0100, 4'b1000 in separate cycles -> eat_combo 0,1,2,3; repeat eat of ghost 0 -> no eat_valid.
REQ-037 power, ghost_eaten 4'b0011 in one cycle, then 4'b0100 -> eat_combo 0 then 2; combo saturates at 3 after next eat.
REQ-038 power at cnt=2 with scene forced 2'b00 -> all outputs 0 next cycle, no power_done; same with rst.
REQ-039 POWER_PAUSE_EN defined: power, pause=1 for 10 ticks -> cnt stays 8; undefined -> cnt reaches 0.
